otter_mem_arbiter: RTL and testbench

//  Shares one single-ported OTTER memory/IO bus between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/otter_arb_pkg.sv | 9 +
 rtl/otter_mem_arbiter_if.sv | 44 ++++
 rtl/otter_arb_timer.sv | 33 +++
 rtl/otter_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_otter_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER single-port memory arbiter.
package otter_arb_pkg;

  typedef enum logic [1:0] {IDLE, IF_XFER, D_XFER} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// Pipeline (IF/MEM stage) and memory-side signals of the OTTER memory arbiter.
// master = arbiter view, slave = pipeline stages plus memory.
interface otter_mem_arbiter_if;

  logic        IF_REQ;
  logic [31:0] IF_ADDR;
  logic [31:0] IF_RDATA;
  logic        IF_ACK;

  logic        D_REQ;
  logic        D_WE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic [1:0]  D_SIZE;
  logic        D_SIGN;
  logic [31:0] D_RDATA;
  logic        D_ACK;

  logic        M_REQ;
  logic        M_WE;
  logic [31:0] M_ADDR;
  logic [31:0] M_WDATA;
  logic [1:0]  M_SIZE;
  logic        M_SIGN;
  logic [31:0] M_RDATA;
  logic        M_READY;

  logic        TO_ERR;

  modport master (
    input  IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
    input  M_RDATA, M_READY,
    output IF_RDATA, IF_ACK, D_RDATA, D_ACK, TO_ERR,
    output M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE, M_SIGN
  );

  modport slave (
    output IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
    output M_RDATA, M_READY,
    input  IF_RDATA, IF_ACK, D_RDATA, D_ACK, TO_ERR,
    input  M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE, M_SIGN
  );

endinterface

// File: rtl/otter_arb_timer.sv
// Saturating 8-bit transfer timer; EXPIRED flags the cycle in which the count
// of not-ready transfer cycles reaches TIMEOUT_CYC.
module otter_arb_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CLR,
  input  logic EN,
  output logic EXPIRED
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC);

  logic [7:0] cnt_q;
  logic [7:0] cnt_inc;

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Counting this cycle included, so the Nth stalled cycle is the one that expires.
  assign EXPIRED = EN && (cnt_inc == LIMIT);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else if (CLR) begin
      cnt_q <= '0;
    end else if (EN) begin
      cnt_q <= cnt_inc;
    end
  end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares one single-ported OTTER memory bus between IF and MEM stages.
// Build option: OTTER_ARB_RR_EN selects round-robin instead of fixed D-over-IF priority.
module otter_mem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                CLK,
  input  logic                RESET,
  otter_mem_arbiter_if.master bus,
  output arb_state_t          dbg_state
);

  // Handshake: a stage raises *_REQ with stable inputs and holds it until its
  // one-cycle *_ACK; the memory ends a transfer by asserting M_READY while M_REQ is high.

  arb_state_t  state_q, state_d;
  arb_owner_t  gnt_own, conflict_own;
  logic        grant;
  logic        done, expired, timer_en, xfer;

  logic        we_q, sign_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;

  assign xfer     = (state_q != IDLE);
  assign timer_en = xfer && !bus.M_READY;
  assign done     = xfer && (bus.M_READY || expired);

`ifdef OTTER_ARB_RR_EN
  arb_owner_t last_gnt_q;

  assign conflict_own = (last_gnt_q == OWN_IF) ? OWN_D : OWN_IF;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_gnt_q <= OWN_IF;
    end else if (grant) begin
      last_gnt_q <= gnt_own;
    end
  end
`else
  assign conflict_own = OWN_D;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // On completion the just-served stage is excluded: its REQ is still high this cycle.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    gnt_own = OWN_IF;
    case (state_q)
      IDLE: begin
        if (bus.IF_REQ && bus.D_REQ) begin
          grant   = 1'b1;
          gnt_own = conflict_own;
        end else if (bus.D_REQ) begin
          grant   = 1'b1;
          gnt_own = OWN_D;
        end else if (bus.IF_REQ) begin
          grant   = 1'b1;
          gnt_own = OWN_IF;
        end
      end
      IF_XFER: begin
        if (done) begin
          state_d = IDLE;
          if (bus.D_REQ) begin
            grant   = 1'b1;
            gnt_own = OWN_D;
          end
        end
      end
      D_XFER: begin
        if (done) begin
          state_d = IDLE;
          if (bus.IF_REQ) begin
            grant   = 1'b1;
            gnt_own = OWN_IF;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      state_d = (gnt_own == OWN_D) ? D_XFER : IF_XFER;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
    end else if (grant) begin
      if (gnt_own == OWN_D) begin
        we_q    <= bus.D_WE;
        addr_q  <= bus.D_ADDR;
        wdata_q <= bus.D_WDATA;
        size_q  <= bus.D_SIZE;
        sign_q  <= bus.D_SIGN;
      end else begin
        we_q    <= 1'b0;
        addr_q  <= bus.IF_ADDR;
        wdata_q <= '0;
        size_q  <= SIZE_WORD;
        sign_q  <= 1'b0;
      end
    end
  end

  otter_arb_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .CLR     (grant),
    .EN      (timer_en),
    .EXPIRED (expired)
  );

  assign bus.M_REQ    = xfer;
  assign bus.M_WE     = we_q;
  assign bus.M_ADDR   = addr_q;
  assign bus.M_WDATA  = wdata_q;
  assign bus.M_SIZE   = size_q;
  assign bus.M_SIGN   = sign_q;

  assign bus.IF_ACK   = (state_q == IF_XFER) && done;
  assign bus.D_ACK    = (state_q == D_XFER) && done;
  assign bus.TO_ERR   = expired;
  assign bus.IF_RDATA = (bus.IF_ACK && !expired) ? bus.M_RDATA : '0;
  assign bus.D_RDATA  = (bus.D_ACK && !we_q && !expired) ? bus.M_RDATA : '0;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed, table-driven bench for otter_mem_arbiter with TIMEOUT_CYC = 4.
module tb_otter_mem_arbiter;
  import otter_arb_pkg::*;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_sign;
    logic        m_ready;
    logic [31:0] m_rdata;
  } in_t;

  typedef struct {
    arb_state_t  st;
    logic        chk_m;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_size;
    logic        m_sign;
    logic        if_ack;
    logic        d_ack;
    logic        to_err;
    logic [31:0] if_rdata;
    logic [31:0] d_rdata;
  } ex_t;

  typedef struct {
    string nm;
    in_t   i;
    ex_t   e;
  } vec_t;

  logic       clk;
  logic       rst_n;
  arb_state_t dbg_state;
  int         n_cmp;
  int         n_bad;
  logic [33:0] exp_q[$];
  vec_t       tbl[$];

  otter_mem_arbiter_if bus();

  otter_mem_arbiter #(.TIMEOUT_CYC(4)) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic in_t vi(logic ifr, logic [31:0] ifa, logic dr, logic dwe,
                             logic [31:0] da, logic [31:0] dwd, logic [1:0] dsz,
                             logic dsg, logic rdy, logic [31:0] rd);
    in_t r;
    r.if_req = ifr; r.if_addr = ifa; r.d_req = dr; r.d_we = dwe; r.d_addr = da;
    r.d_wdata = dwd; r.d_size = dsz; r.d_sign = dsg; r.m_ready = rdy; r.m_rdata = rd;
    return r;
  endfunction

  function automatic ex_t ve(arb_state_t st, logic chk, logic we, logic [31:0] ad,
                             logic [31:0] wd, logic [1:0] sz, logic sg, logic ia,
                             logic da, logic te, logic [31:0] ir, logic [31:0] dr);
    ex_t r;
    r.st = st; r.chk_m = chk; r.m_we = we; r.m_addr = ad; r.m_wdata = wd; r.m_size = sz;
    r.m_sign = sg; r.if_ack = ia; r.d_ack = da; r.to_err = te; r.if_rdata = ir; r.d_rdata = dr;
    return r;
  endfunction

  function automatic vec_t mk(string nm, in_t i, ex_t e);
    vec_t v;
    v.nm = nm; v.i = i; v.e = e;
    return v;
  endfunction

  function automatic ex_t ve_idle();
    return ve(IDLE, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endfunction

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // driver
  task automatic drive(input in_t i);
    bus.IF_REQ  = i.if_req;
    bus.IF_ADDR = i.if_addr;
    bus.D_REQ   = i.d_req;
    bus.D_WE    = i.d_we;
    bus.D_ADDR  = i.d_addr;
    bus.D_WDATA = i.d_wdata;
    bus.D_SIZE  = i.d_size;
    bus.D_SIGN  = i.d_sign;
    bus.M_READY = i.m_ready;
    bus.M_RDATA = i.m_rdata;
  endtask

  // One clock cycle: inputs change on the falling edge, outputs checked 1 ns later.
  task automatic run_vec(input vec_t v);
    logic [33:0] got, want;
    if (v.e.if_ack || v.e.d_ack)
      exp_q.push_back({v.e.d_ack, v.e.to_err, v.e.d_ack ? v.e.d_rdata : v.e.if_rdata});
    @(negedge clk);
    drive(v.i);
    #1;
    chk({v.nm, ".state"},    34'(dbg_state),     34'(v.e.st));
    chk({v.nm, ".m_req"},    34'(bus.M_REQ),     34'(v.e.st != IDLE));
    chk({v.nm, ".if_ack"},   34'(bus.IF_ACK),    34'(v.e.if_ack));
    chk({v.nm, ".d_ack"},    34'(bus.D_ACK),     34'(v.e.d_ack));
    chk({v.nm, ".to_err"},   34'(bus.TO_ERR),    34'(v.e.to_err));
    chk({v.nm, ".if_rdata"}, 34'(bus.IF_RDATA),  34'(v.e.if_rdata));
    chk({v.nm, ".d_rdata"},  34'(bus.D_RDATA),   34'(v.e.d_rdata));
    if (v.e.chk_m) begin
      chk({v.nm, ".m_we"},    34'(bus.M_WE),    34'(v.e.m_we));
      chk({v.nm, ".m_addr"},  34'(bus.M_ADDR),  34'(v.e.m_addr));
      chk({v.nm, ".m_wdata"}, 34'(bus.M_WDATA), 34'(v.e.m_wdata));
      chk({v.nm, ".m_size"},  34'(bus.M_SIZE),  34'(v.e.m_size));
      chk({v.nm, ".m_sign"},  34'(bus.M_SIGN),  34'(v.e.m_sign));
    end
    // scoreboard: every observed completion must match the next expected one
    if (bus.IF_ACK || bus.D_ACK) begin
      got = {bus.D_ACK, bus.TO_ERR, bus.D_ACK ? bus.D_RDATA : bus.IF_RDATA};
      if (exp_q.size() == 0) begin
        chk({v.nm, ".sb_unexpected"}, got, 34'h0);
      end else begin
        want = exp_q.pop_front();
        chk({v.nm, ".sb"}, got, want);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rst.state",  34'(dbg_state),  34'(IDLE));
    chk("rst.m_req",  34'(bus.M_REQ),  34'h0);
    chk("rst.acks",   34'({bus.IF_ACK, bus.D_ACK, bus.TO_ERR}), 34'h0);
    chk("rst.m_addr", 34'(bus.M_ADDR), 34'h0);
    chk("rst.m_we",   34'(bus.M_WE),   34'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // IF-only fetch, ready on 2nd transfer cycle; ready in IDLE is ignored
    tbl.push_back(mk("s1_idle", vi(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0), ve_idle()));
    tbl.push_back(mk("s1_x1",   vi(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0),
                     ve(IF_XFER, 1, 0, 32'h100, 0, 2'b10, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk("s1_ack",  vi(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 32'h00500093),
                     ve(IF_XFER, 1, 0, 32'h100, 0, 2'b10, 0, 1, 0, 0, 32'h00500093, 0)));
    tbl.push_back(mk("s1_done", vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF), ve_idle()));
    // same-cycle IF and D store: D first, chains to IF with no idle bubble
    tbl.push_back(mk("s2_conf", vi(1, 32'h200, 1, 1, 32'h1100, 32'hCAFEF00D, 2'b10, 0, 0, 0), ve_idle()));
    tbl.push_back(mk("s2_dx",   vi(1, 32'h200, 1, 1, 32'h1100, 32'hCAFEF00D, 2'b10, 0, 0, 0),
                     ve(D_XFER, 1, 1, 32'h1100, 32'hCAFEF00D, 2'b10, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk("s2_dack", vi(1, 32'h200, 1, 1, 32'h1100, 32'hCAFEF00D, 2'b10, 0, 1, 32'hDEADBEEF),
                     ve(D_XFER, 1, 1, 32'h1100, 32'hCAFEF00D, 2'b10, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(mk("s2_chain", vi(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0),
                     ve(IF_XFER, 1, 0, 32'h200, 0, 2'b10, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk("s2_iack", vi(1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'h11111111),
                     ve(IF_XFER, 1, 0, 32'h200, 0, 2'b10, 0, 1, 0, 0, 32'h11111111, 0)));
    tbl.push_back(mk("s2_idle", vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ve_idle()));
    // D load never ready: timeout on the 4th transfer cycle
    tbl.push_back(mk("s4_req", vi(0, 0, 1, 0, 32'h1104, 0, 2'b10, 0, 0, 0), ve_idle()));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk($sformatf("s4_x%0d", k), vi(0, 0, 1, 0, 32'h1104, 0, 2'b10, 0, 0, 0),
                       ve(D_XFER, 1, 0, 32'h1104, 0, 2'b10, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk("s4_to", vi(0, 0, 1, 0, 32'h1104, 0, 2'b10, 0, 0, 32'hAAAAAAAA),
                     ve(D_XFER, 1, 0, 32'h1104, 0, 2'b10, 0, 0, 1, 1, 0, 0)));
    tbl.push_back(mk("s4_idle", vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ve_idle()));
    // ready lands on the timeout cycle: normal completion, unsigned byte load
    tbl.push_back(mk("s5_req", vi(0, 0, 1, 0, 32'h1104, 0, 2'b00, 1, 0, 0), ve_idle()));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk($sformatf("s5_x%0d", k), vi(0, 0, 1, 0, 32'h1104, 0, 2'b00, 1, 0, 0),
                       ve(D_XFER, 1, 0, 32'h1104, 0, 2'b00, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(mk("s5_rdy", vi(0, 0, 1, 0, 32'h1104, 0, 2'b00, 1, 1, 32'h12345678),
                     ve(D_XFER, 1, 0, 32'h1104, 0, 2'b00, 1, 0, 1, 0, 0, 32'h12345678)));
    tbl.push_back(mk("s5_idle", vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ve_idle()));

    do_reset();
    foreach (tbl[k]) run_vec(tbl[k]);

    // arbitration history from reset (LAST_GNT starts as IF)
    do_reset();
    run_vec(mk("s3_conf", vi(1, 32'h400, 1, 0, 32'h1200, 0, 2'b10, 0, 0, 0), ve_idle()));
    run_vec(mk("s3_d", vi(1, 32'h400, 1, 0, 32'h1200, 0, 2'b10, 0, 1, 32'h42),
               ve(D_XFER, 1, 0, 32'h1200, 0, 2'b10, 0, 0, 1, 0, 0, 32'h42)));
    run_vec(mk("s3_if", vi(1, 32'h400, 0, 0, 0, 0, 0, 0, 1, 32'h13),
               ve(IF_XFER, 1, 0, 32'h400, 0, 2'b10, 0, 1, 0, 0, 32'h13, 0)));
    run_vec(mk("s3_donly", vi(0, 0, 1, 0, 32'h1204, 0, 2'b10, 0, 0, 0), ve_idle()));
    run_vec(mk("s3_dack", vi(0, 0, 1, 0, 32'h1204, 0, 2'b10, 0, 1, 32'h77),
               ve(D_XFER, 1, 0, 32'h1204, 0, 2'b10, 0, 0, 1, 0, 0, 32'h77)));
    run_vec(mk("s3_conf2", vi(1, 32'h404, 1, 0, 32'h1208, 0, 2'b10, 0, 0, 0), ve_idle()));
`ifdef OTTER_ARB_RR_EN
    run_vec(mk("s3_gnt2", vi(1, 32'h404, 1, 0, 32'h1208, 0, 2'b10, 0, 0, 0),
               ve(IF_XFER, 1, 0, 32'h404, 0, 2'b10, 0, 0, 0, 0, 0, 0)));
`else
    run_vec(mk("s3_gnt2", vi(1, 32'h404, 1, 0, 32'h1208, 0, 2'b10, 0, 0, 0),
               ve(D_XFER, 1, 0, 32'h1208, 0, 2'b10, 0, 0, 0, 0, 0, 0)));
`endif

    // asynchronous reset in the middle of a fetch, request held throughout
    do_reset();
    run_vec(mk("s6_req", vi(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0), ve_idle()));
    run_vec(mk("s6_x1", vi(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0),
               ve(IF_XFER, 1, 0, 32'h300, 0, 2'b10, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    #1;
    chk("s6_x2.state", 34'(dbg_state), 34'(IF_XFER));
    rst_n = 1'b0;
    bus.M_READY = 1'b1;
    bus.M_RDATA = 32'h55555555;
    #1;
    chk("s6_abort.m_req",  34'(bus.M_REQ),  34'h0);
    chk("s6_abort.if_ack", 34'(bus.IF_ACK), 34'h0);
    chk("s6_abort.d_ack",  34'(bus.D_ACK),  34'h0);
    chk("s6_abort.to_err", 34'(bus.TO_ERR), 34'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.M_READY = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("s6_rel.state", 34'(dbg_state), 34'(IDLE));
    chk("s6_rel.m_req", 34'(bus.M_REQ), 34'h0);
    run_vec(mk("s6_reissue", vi(1, 32'h300, 0, 0, 0, 0, 0, 0, 1, 32'h66),
               ve(IF_XFER, 1, 0, 32'h300, 0, 2'b10, 0, 1, 0, 0, 32'h66, 0)));
    run_vec(mk("s6_idle", vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ve_idle()));

    chk("sb.drain", 34'(exp_q.size()), 34'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
